// File: rtl/ddr_burst_model.sv
// Behavioural DDR read/write endpoint: fixed-latency read bursts from a
// zero-initialised backing store, single-word writes, and usage statistics.
module ddr_burst_model #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned LEN_W        = 8,
  parameter int unsigned MEM_DEPTH    = 4096,
  parameter int unsigned READ_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ddr_read_req,
  input  logic [ADDR_W-1:0] ddr_read_addr,
  input  logic [LEN_W-1:0]  ddr_read_len,
  output logic              ddr_read_grant,
  output logic [DATA_W-1:0] ddr_read_data,
  output logic              ddr_read_valid,
  input  logic              ddr_write_req,
  input  logic [ADDR_W-1:0] ddr_write_addr,
  input  logic [DATA_W-1:0] ddr_write_data,
  output logic              ddr_write_grant,
  output logic              addr_err,
  output logic [31:0]       stat_rd_beats,
  output logic [31:0]       stat_writes
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
  localparam int unsigned LAT_W = $clog2(READ_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, LAT, BURST} state_e;

  state_e              state_q;
  logic [LAT_W-1:0]    lat_cnt_q;
  logic [IDX_W-1:0]    idx_q;
  logic [LEN_W-1:0]    rem_q;
  logic                rd_grant_q;
  logic                rd_valid_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                wr_grant_q;
  logic                addr_err_q;
  logic [31:0]         stat_rd_q;
  logic [31:0]         stat_rd_d;
  logic [31:0]         stat_wr_q;
  logic [31:0]         stat_wr_d;
  logic                addr_err_d;
  logic [DATA_W-1:0]   mem_q [MEM_DEPTH];
  logic [MEM_DEPTH-1:0] written_q;

  logic                wr_accept;
  logic                wr_in_range;
  logic                wr_commit;
  logic [IDX_W-1:0]    wr_idx;
  logic                rd_start;
  logic                rd_in_range;
  logic                beat_fire;
  logic [DATA_W-1:0]   beat_data;

  assign wr_accept   = ddr_write_req && !wr_grant_q;
  assign wr_in_range = (ddr_write_addr >> IDX_W) == '0;
  assign wr_commit   = wr_accept && wr_in_range;
  assign wr_idx      = ddr_write_addr[IDX_W-1:0];
  assign rd_start    = (state_q == IDLE) && ddr_read_req;
  assign rd_in_range = (ddr_read_addr >> IDX_W) == '0;
  assign beat_fire   = ((state_q == LAT) && (lat_cnt_q == LAT_W'(1))) || (state_q == BURST);

  // A write accepted on the same edge as a beat is forwarded so the beat never sees stale data
  always_comb begin
    beat_data = '0;
    if (wr_commit && (wr_idx == idx_q)) begin
      beat_data = ddr_write_data;
    end else if (written_q[idx_q]) begin
      beat_data = mem_q[idx_q];
    end
  end

  always_comb begin
    stat_rd_d  = stat_rd_q;
    stat_wr_d  = stat_wr_q;
    addr_err_d = addr_err_q;
    if (beat_fire && (stat_rd_q != 32'hFFFF_FFFF)) stat_rd_d = stat_rd_q + 32'd1;
    if (wr_commit && (stat_wr_q != 32'hFFFF_FFFF)) stat_wr_d = stat_wr_q + 32'd1;
    if ((wr_accept && !wr_in_range) || (rd_start && !rd_in_range)) addr_err_d = 1'b1;
  end

  // Read FSM: latency countdown, then one beat per cycle with wrapping index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lat_cnt_q  <= '0;
      idx_q      <= '0;
      rem_q      <= '0;
      rd_grant_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_grant_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      case (state_q)
        IDLE: begin
          if (ddr_read_req) begin
            idx_q      <= ddr_read_addr[IDX_W-1:0];
            rem_q      <= ddr_read_len;
            lat_cnt_q  <= LAT_W'(READ_LATENCY);
            rd_grant_q <= 1'b1;
            state_q    <= LAT;
          end
        end
        LAT: begin
          if (lat_cnt_q == LAT_W'(1)) begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= beat_data;
            idx_q      <= idx_q + IDX_W'(1);
            state_q    <= (rem_q == '0) ? IDLE : BURST;
          end else begin
            lat_cnt_q <= lat_cnt_q - LAT_W'(1);
          end
        end
        BURST: begin
          rd_valid_q <= 1'b1;
          rd_data_q  <= beat_data;
          idx_q      <= idx_q + IDX_W'(1);
          rem_q      <= rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_grant_q <= 1'b0;
      addr_err_q <= 1'b0;
      stat_rd_q  <= '0;
      stat_wr_q  <= '0;
      written_q  <= '0;
    end else begin
      wr_grant_q <= wr_accept;
      addr_err_q <= addr_err_d;
      stat_rd_q  <= stat_rd_d;
      stat_wr_q  <= stat_wr_d;
      if (wr_commit) written_q[wr_idx] <= 1'b1;
    end
  end

  // Storage itself needs no reset; the written bits mask stale contents
  always_ff @(posedge clk) begin
    if (wr_commit) mem_q[wr_idx] <= ddr_write_data;
  end

  assign ddr_read_grant  = rd_grant_q;
  assign ddr_read_valid  = rd_valid_q;
  assign ddr_read_data   = rd_data_q;
  assign ddr_write_grant = wr_grant_q;
  assign addr_err        = addr_err_q;
  assign stat_rd_beats   = stat_rd_q;
  assign stat_writes     = stat_wr_q;

endmodule

// File: tb/tb_ddr_burst_model.sv
// Directed bench for ddr_burst_model: a default-depth instance and a 16-word
// instance share all inputs; outputs are checked on the falling clock edge.
module tb_ddr_burst_model;

  localparam int unsigned RL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic [7:0]  rd_len;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  logic        rd_grant, rd_valid, wr_grant, a_err;
  logic [31:0] rd_data, st_rd, st_wr;
  logic        s_rd_grant, s_rd_valid, s_wr_grant, s_a_err;
  logic [31:0] s_rd_data, s_st_rd, s_st_wr;

  int total = 0;
  int bad = 0;
  int exp_rd = 0;
  int exp_wr = 0;
  logic [31:0] expv [16];

  always #5 clk = ~clk;

  ddr_burst_model #(.READ_LATENCY(RL)) u_big (
    .clk(clk), .rst(rst),
    .ddr_read_req(rd_req), .ddr_read_addr(rd_addr), .ddr_read_len(rd_len),
    .ddr_read_grant(rd_grant), .ddr_read_data(rd_data), .ddr_read_valid(rd_valid),
    .ddr_write_req(wr_req), .ddr_write_addr(wr_addr), .ddr_write_data(wr_data),
    .ddr_write_grant(wr_grant), .addr_err(a_err),
    .stat_rd_beats(st_rd), .stat_writes(st_wr)
  );

  ddr_burst_model #(.MEM_DEPTH(16), .READ_LATENCY(RL)) u_small (
    .clk(clk), .rst(rst),
    .ddr_read_req(rd_req), .ddr_read_addr(rd_addr), .ddr_read_len(rd_len),
    .ddr_read_grant(s_rd_grant), .ddr_read_data(s_rd_data), .ddr_read_valid(s_rd_valid),
    .ddr_write_req(wr_req), .ddr_write_addr(wr_addr), .ddr_write_data(wr_data),
    .ddr_write_grant(s_wr_grant), .addr_err(s_a_err),
    .stat_rd_beats(s_st_rd), .stat_writes(s_st_wr)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [31:0] e0, e1, e2, e3;
  } rvec_t;

  rvec_t tbl [5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
    end
  endtask

  task automatic write_word(input string nm, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    wr_req = 1'b1; wr_addr = addr; wr_data = data;
    @(negedge clk);
    check({nm, ".wgrant"}, 32'(wr_grant), 32'd1);
    wr_req = 1'b0;
    if (addr < 32'd4096) exp_wr++;
    @(negedge clk);
    check({nm, ".wgrant_off"}, 32'(wr_grant), 32'd0);
  endtask

  // Full-burst timing check against expv[0..len]
  task automatic read_burst(input string nm, input logic [31:0] addr, input logic [7:0] len, input bit sm);
    @(negedge clk);
    rd_req = 1'b1; rd_addr = addr; rd_len = len;
    @(negedge clk);
    rd_req = 1'b0;
    check({nm, ".grant"}, 32'(sm ? s_rd_grant : rd_grant), 32'd1);
    check({nm, ".early_valid"}, 32'(sm ? s_rd_valid : rd_valid), 32'd0);
    for (int k = 1; k < int'(RL); k++) begin
      @(negedge clk);
      if (k == 1) check({nm, ".grant_pulse"}, 32'(sm ? s_rd_grant : rd_grant), 32'd0);
      check({nm, ".lat_valid"}, 32'(sm ? s_rd_valid : rd_valid), 32'd0);
    end
    for (int i = 0; i <= int'(len); i++) begin
      @(negedge clk);
      check($sformatf("%s.valid%0d", nm, i), 32'(sm ? s_rd_valid : rd_valid), 32'd1);
      check($sformatf("%s.data%0d", nm, i), sm ? s_rd_data : rd_data, expv[i]);
    end
    @(negedge clk);
    check({nm, ".tail_valid"}, 32'(sm ? s_rd_valid : rd_valid), 32'd0);
    check({nm, ".tail_data"}, sm ? s_rd_data : rd_data, 32'd0);
    exp_rd += int'(len) + 1;
  endtask

  initial begin
    int grants;
    int stray;

    tbl[0] = '{32'h10,  8'd0, 32'hA5A5_0001, 32'h0,         32'h0,         32'h0};
    tbl[1] = '{32'h12,  8'd1, 32'hA5A5_0003, 32'hA5A5_0004, 32'h0,         32'h0};
    tbl[2] = '{32'h11,  8'd3, 32'hA5A5_0002, 32'hA5A5_0003, 32'hA5A5_0004, 32'h0};
    tbl[3] = '{32'h0F,  8'd1, 32'h0,         32'hA5A5_0001, 32'h0,         32'h0};
    tbl[4] = '{32'hFFF, 8'd1, 32'h77,        32'h0,         32'h0,         32'h0};

    rst = 1'b1; rd_req = 1'b0; rd_addr = '0; rd_len = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst.grant", 32'(rd_grant), 32'd0);
    check("rst.valid", 32'(rd_valid), 32'd0);
    check("rst.data", rd_data, 32'd0);
    check("rst.wgrant", 32'(wr_grant), 32'd0);
    check("rst.err", 32'(a_err), 32'd0);
    check("rst.st_rd", st_rd, 32'd0);
    check("rst.st_wr", st_wr, 32'd0);
    rst = 1'b0;

    // Basic write-then-burst
    for (int i = 0; i < 4; i++) write_word("w_a5", 32'h10 + 32'(i), 32'hA5A5_0001 + 32'(i));
    for (int i = 0; i < 4; i++) expv[i] = 32'hA5A5_0001 + 32'(i);
    read_burst("burst4", 32'h10, 8'd3, 1'b0);
    check("burst4.st_wr", st_wr, 32'd4);
    check("burst4.st_rd", st_rd, 32'd4);

    expv[0] = 32'h0;
    read_burst("unwritten", 32'h20, 8'd0, 1'b0);
    check("unwritten.err", 32'(a_err), 32'd0);

    write_word("w_top", 32'hFFF, 32'h77);
    for (int i = 0; i < 5; i++) begin
      expv[0] = tbl[i].e0; expv[1] = tbl[i].e1; expv[2] = tbl[i].e2; expv[3] = tbl[i].e3;
      read_burst($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].len, 1'b0);
    end
    check("tbl.err", 32'(a_err), 32'd0);
    check("tbl.st_rd", st_rd, 32'(exp_rd));

    // Out-of-range write is granted but dropped
    write_word("w_oor", 32'd5000, 32'hDEAD_BEEF);
    check("oor.err", 32'(a_err), 32'd1);
    check("oor.st_wr", st_wr, 32'(exp_wr));
    expv[0] = 32'h0;
    read_burst("oor_alias", 32'd904, 8'd0, 1'b0);
    expv[0] = 32'hA5A5_0001; expv[1] = 32'hA5A5_0002; expv[2] = 32'hA5A5_0003;
    read_burst("rd_oor_wrap", 32'h1010, 8'd2, 1'b0);

    // Write during latency, write_req held four cycles
    for (int i = 0; i < 16; i++) expv[i] = 32'h0;
    expv[5] = 32'h0000_BEEF;
    @(negedge clk);
    rd_req = 1'b1; rd_addr = 32'h40; rd_len = 8'd7;
    @(negedge clk);
    rd_req = 1'b0;
    check("lat_wr.grant", 32'(rd_grant), 32'd1);
    wr_req = 1'b1; wr_addr = 32'h45; wr_data = 32'h0000_BEEF;
    grants = 0;
    for (int c = 1; c <= int'(RL) + 8; c++) begin
      @(negedge clk);
      grants += int'(wr_grant);
      if (c == 4) wr_req = 1'b0;
      if (c >= int'(RL) && c <= int'(RL) + 7) begin
        check($sformatf("lat_wr.valid%0d", c - int'(RL)), 32'(rd_valid), 32'd1);
        check($sformatf("lat_wr.data%0d", c - int'(RL)), rd_data, expv[c - int'(RL)]);
      end else begin
        check($sformatf("lat_wr.idle%0d", c), 32'(rd_valid), 32'd0);
      end
    end
    check("lat_wr.wgrants", 32'(grants), 32'd2);
    exp_wr += 2;
    exp_rd += 8;
    check("lat_wr.st_wr", st_wr, 32'(exp_wr));
    check("lat_wr.st_rd", st_rd, 32'(exp_rd));

    // 16-word instance wraps mid-burst
    write_word("w_s15", 32'd15, 32'h11);
    write_word("w_s0", 32'd0, 32'h22);
    expv[0] = 32'h11; expv[1] = 32'h22;
    read_burst("small_wrap", 32'd15, 8'd1, 1'b1);

    // Reset on the third beat of an 8-beat burst
    @(negedge clk);
    rd_req = 1'b1; rd_addr = 32'h10; rd_len = 8'd7;
    @(negedge clk);
    rd_req = 1'b0;
    for (int k = 0; k < int'(RL) - 1 + 3; k++) @(negedge clk);
    check("mid.valid_before", 32'(rd_valid), 32'd1);
    check("mid.data_before", rd_data, 32'hA5A5_0003);
    rst = 1'b1;
    #1;
    check("mid.valid_rst", 32'(rd_valid), 32'd0);
    check("mid.data_rst", rd_data, 32'd0);
    check("mid.st_rd_rst", st_rd, 32'd0);
    check("mid.st_wr_rst", st_wr, 32'd0);
    check("mid.err_rst", 32'(a_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_rd = 0; exp_wr = 0;
    stray = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      stray += int'(rd_valid);
    end
    check("mid.no_beats", 32'(stray), 32'd0);
    expv[0] = 32'h0;
    read_burst("post_rst", 32'h10, 8'd0, 1'b0);
    check("post_rst.st_rd", st_rd, 32'(exp_rd));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
